pll_reset_ctrl: RTL
===================

// Module: pll_reset_ctrl
//
// PURPOSE
//   Upstream reset/relock controller for the system PLL. Runs on the 50 MHz reference clock.
//   Drives the PLL 'rst' input, monitors the PLL 'locked' output, retries on lock timeout and
//   re-locks after sustained lock loss. Releases a system reset only after lock has been stable
//   for a programmable time. Consumers must synchronise sys_rst into the 35 MHz domains.
//
// PARAMETERS
//   RST_CYCLES     16     cycles pll_rst is held high per reset pulse (>=1)
//   LOCK_TIMEOUT   50000  cycles to wait for lock after pll_rst release before retrying (1 ms @ 50 MHz)
//   STABLE_CYCLES  1024   consecutive locked cycles required before sys_rst release (>=1)
//   FILTER_CYCLES  4      consecutive unlocked cycles in RUN that count as lock loss (>=1)
//   CNT_W          4      width of retry_cnt (saturating)
//
// PORTS
//   refclk      in   1      50 MHz reference clock; all flops on rising edge
//   rst         in   1      asynchronous, active-high reset
//   pll_locked  in   1      PLL locked output; asynchronous to refclk
//   pll_rst     out  1      reset to PLL; high = PLL held in reset
//   sys_rst     out  1      system reset; high until PLL lock is stable
//   ready       out  1      high only in RUN state (equals ~sys_rst)
//   lock_lost   out  1      sticky: set on any lock loss detected in RUN; cleared only by rst
//   retry_cnt   out  CNT_W  count of PLL re-resets (timeouts + lock losses); saturates at all-ones
//
// BEHAVIOUR
//   Sync: pll_locked passes through 2 flops (reset 0) -> locked_s; 2-cycle latency; FSM uses locked_s only.
//   Reset (rst=1, async): state=RESET_PLL, cnt=0, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, retry_cnt=0.
//   Single counter cnt, width $clog2(max(all cycle params)+1); cleared on every state change.
//   Outputs are flops loaded with the decode of next state, so they change on the same edge as the state; glitch-free.
//   States / transitions (evaluated each refclk edge):
//     RESET_PLL: pll_rst=1, sys_rst=1. cnt++; at cnt==RST_CYCLES-1 -> WAIT_LOCK.
//     WAIT_LOCK: pll_rst=0, sys_rst=1. If locked_s -> STABLE.
//                Else at cnt==LOCK_TIMEOUT-1 -> RESET_PLL, retry_cnt++.
//     STABLE:    pll_rst=0, sys_rst=1. If !locked_s -> WAIT_LOCK (timeout restarts from 0; no retry increment).
//                Else at cnt==STABLE_CYCLES-1 -> RUN.
//     RUN:       pll_rst=0, sys_rst=0, ready=1. cnt counts consecutive !locked_s cycles and clears when locked_s=1.
//                At the FILTER_CYCLES-th consecutive unlocked cycle -> RESET_PLL, lock_lost=1, retry_cnt++.
//   pll_rst high time per pulse: exactly RST_CYCLES cycles. Lock-timeout window: exactly LOCK_TIMEOUT cycles of pll_rst=0.
//   Lock rise (pin) -> sys_rst fall: 2 (sync) + STABLE_CYCLES cycles.
//   retry_cnt saturates at 2^CNT_W-1 and never wraps. The FSM keeps retrying indefinitely; no terminal fail state.
//   Simultaneous locked_s rise and timeout terminal count in WAIT_LOCK: lock wins -> STABLE.
//   Simultaneous locked_s return and filter terminal count in RUN: cannot occur, because the terminal count requires locked_s=0 on that cycle.
//   rst asserted mid-operation: every output returns to its reset value immediately, without waiting for refclk.
//   rst release: first active edge begins the RESET_PLL count.
//
// TESTING (bench params: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, FILTER_CYCLES=3, CNT_W=4)
//   1. Release rst, pll_locked=0 forever -> pll_rst high 4 cycles, low 20, high 4 (repeating); retry_cnt=1,2,3...; sys_rst stays 1.
//   2. pll_locked rises 5 cycles into WAIT_LOCK -> STABLE entered 2 cycles later; sys_rst falls and ready rises 8 cycles after that; retry_cnt=0.
//   3. In RUN, drop pll_locked for 2 cycles -> no output change. Drop for 3+ cycles -> pll_rst=1, sys_rst=1, lock_lost=1, retry_cnt+1; relock and re-run.
//   4. In STABLE at cnt=6, pulse pll_locked low for 1 cycle -> return to WAIT_LOCK; after relock, sys_rst release takes a full fresh 8 cycles; retry_cnt unchanged.
//   5. Hold pll_locked=0 through 20 timeouts -> retry_cnt reaches 15 and holds at 15.
//   6. Assert rst asynchronously (between edges) while in RUN -> pll_rst=1, sys_rst=1, ready=0, lock_lost=0, retry_cnt=0 before the next refclk edge.

Source files
------------

// File: rtl/pll_reset_ctrl_if.sv
// Status and control signals between the PLL reset controller and the PLL / system.
interface pll_reset_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic             lock_lost;
  logic [CNT_W-1:0] retry_cnt;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output lock_lost,
    output retry_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  lock_lost,
    input  retry_cnt
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset / relock controller: pulses the PLL reset, waits for a stable lock,
// releases system reset, and re-locks after a timeout or a sustained lock loss.
module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             refclk,
  input  logic             rst,
  pll_reset_ctrl_if.master bus
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD  = (STABLE_CYCLES > FILTER_CYCLES) ? STABLE_CYCLES : FILTER_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             retry_inc;
  logic             sync1_q, locked_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= bus.pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // State, shared counter, sticky flag, retry count and decoded outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    lost_d    = lost_q;
    retry_inc = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes priority over the retry.
        if (locked_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d   = RESET_PLL;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // In RUN the counter tracks consecutive unlocked cycles only.
        if (locked_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
          state_d   = RESET_PLL;
          cnt_d     = '0;
          lost_d    = 1'b1;
          retry_inc = 1'b1;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    retry_d = retry_q;
    if (retry_inc && (retry_q != '1)) begin
      retry_d = retry_q + CNT_W'(1);
    end

    pll_rst_d = (state_d == RESET_PLL);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.lock_lost = lost_q;
  assign bus.retry_cnt = retry_q;

endmodule
